// File: rtl/audio_fifo_pkg.sv
// Shared register map, bit positions and widths for the audio stream FIFO bridge.
package audio_fifo_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned DROP_W = 16;

    // Register indices on the 2-bit bus address
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DROPS  = 2'd3;

    // STATUS bit positions (level occupies the low bits)
    localparam int unsigned ST_EMPTY = 16;
    localparam int unsigned ST_FULL  = 17;
    localparam int unsigned ST_OVF   = 18;
    localparam int unsigned ST_UDF   = 19;
    localparam int unsigned ST_IRQ   = 20;

    // CTRL bit positions (watermark occupies the low bits)
    localparam int unsigned CTRL_IRQ_EN = 16;
    localparam int unsigned CTRL_FLUSH  = 17;

endpackage

// File: rtl/sfifo_dpram.sv
// Simple dual-port RAM: synchronous write port, registered read port with read enable.
module sfifo_dpram #(
    parameter int unsigned WIDTH      = 30,
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output only moves on a read so the bus sees the last popped word held
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/audio_stream_fifo_bridge.sv
// Stream-to-bus bridge: buffers tagged multi-channel samples in a circular FIFO
// and exposes them through a four-register CPU window with status, watermark irq and flush.
module audio_stream_fifo_bridge
    import audio_fifo_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 28,
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 chipselect,
    input  logic [1:0]           address,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    input  logic                 source_valid,
    input  logic [DATA_SIZE-1:0] source_data,
    input  logic [CH_BITS-1:0]   source_channel,
    output logic [CHANNELS-1:0]  source_ready,
    output logic                 irq
);

    localparam int unsigned WORD_W = DATA_SIZE + CH_BITS;
    localparam int unsigned LVL_W  = ADDR_WIDTH + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [LVL_W-1:0]      level;
    logic [LVL_W-1:0]      watermark;
    logic                  irq_en;
    logic                  ovf;
    logic                  udf;
    logic [DROP_W-1:0]     drops;

    logic                  full;
    logic                  empty;
    logic                  rd_access;
    logic                  wr_access;
    logic                  flush;
    logic                  push;
    logic                  pop;
    logic                  pop_empty;
    logic                  drop;
    logic                  clear_err;

    logic                  rd_sel;
    logic [BUS_W-1:0]      reg_rdata;
    logic [BUS_W-1:0]      status_word;
    logic [BUS_W-1:0]      ctrl_word;
    logic [BUS_W-1:0]      rd_mux;
    logic [WORD_W-1:0]     ram_q;
    logic                  unused_wdata;

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

    // Depends only on the level register, never on bus or stream inputs
    assign source_ready = {CHANNELS{~full}};

    // Bus and stream decode; flush suppresses any same-cycle push or pop
    always_comb begin
        rd_access = chipselect && read;
        wr_access = chipselect && write;
        flush     = wr_access && (address == REG_CTRL) && write_data[CTRL_FLUSH];
        clear_err = wr_access && (address == REG_DROPS);
        push      = source_valid && !full && !flush;
        drop      = source_valid && full && !flush;
        pop       = rd_access && (address == REG_DATA) && !empty && !flush;
        pop_empty = rd_access && (address == REG_DATA) && empty && !flush;
    end

    assign unused_wdata = ^write_data;

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: ;
            endcase
        end
    end

    // Sticky error flags and saturating drop counter; a DROPS write wins over new events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf   <= 1'b0;
            udf   <= 1'b0;
            drops <= '0;
        end else if (clear_err) begin
            ovf   <= 1'b0;
            udf   <= 1'b0;
            drops <= '0;
        end else begin
            if (drop) begin
                ovf <= 1'b1;
                if (drops != '1) begin
                    drops <= drops + DROP_W'(1);
                end
            end
            if (pop_empty) begin
                udf <= 1'b1;
            end
        end
    end

    // Control register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            watermark <= '0;
            irq_en    <= 1'b0;
        end else if (wr_access && (address == REG_CTRL)) begin
            watermark <= write_data[LVL_W-1:0];
            irq_en    <= write_data[CTRL_IRQ_EN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en && (level >= watermark) && (watermark != '0);
        end
    end

    always_comb begin
        status_word                = '0;
        status_word[LVL_W-1:0]     = level;
        status_word[ST_EMPTY]      = empty;
        status_word[ST_FULL]       = full;
        status_word[ST_OVF]        = ovf;
        status_word[ST_UDF]        = udf;
        status_word[ST_IRQ]        = irq;

        ctrl_word                  = '0;
        ctrl_word[LVL_W-1:0]       = watermark;
        ctrl_word[CTRL_IRQ_EN]     = irq_en;

        rd_mux = '0;
        case (address)
            REG_STATUS: rd_mux = status_word;
            REG_CTRL:   rd_mux = ctrl_word;
            REG_DROPS:  rd_mux = BUS_W'(drops);
            default:    rd_mux = '0;
        endcase
    end

    // Read return: popped words come straight from the RAM output register,
    // everything else (including an empty pop) from reg_rdata
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_sel    <= 1'b0;
            reg_rdata <= '0;
        end else if (rd_access) begin
            rd_sel    <= pop;
            reg_rdata <= rd_mux;
        end
    end

    assign read_data = rd_sel ? BUS_W'(ram_q) : reg_rdata;

    sfifo_dpram #(
        .WIDTH      (WORD_W),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({source_channel, source_data}),
        .re    (pop),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_audio_stream_fifo_bridge.sv
// Scoreboard bench for audio_stream_fifo_bridge: queue model of FIFO contents and drops.
module tb_audio_stream_fifo_bridge;

    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        chipselect;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        source_valid;
    logic [27:0] source_data;
    logic [0:0]  source_channel;
    logic [1:0]  source_ready;
    logic        irq;

    logic [31:0] sb[$];
    int          drops_m;
    int          n_tests;
    int          n_fail;

    audio_stream_fifo_bridge dut (
        .clk            (clk),
        .rst            (rst),
        .chipselect     (chipselect),
        .address        (address),
        .read           (read),
        .write          (write),
        .write_data     (write_data),
        .read_data      (read_data),
        .source_valid   (source_valid),
        .source_data    (source_data),
        .source_channel (source_channel),
        .source_ready   (source_ready),
        .irq            (irq)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All tasks start and end just after a falling edge
    task automatic push(input logic ch, input logic [27:0] d);
        source_valid   = 1'b1;
        source_channel = ch;
        source_data    = d;
        if (sb.size() < DEPTH) sb.push_back(32'({ch, d}));
        else                   drops_m++;
        @(negedge clk);
        source_valid = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        @(negedge clk);
        d          = read_data;
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] wd);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        write_data = wd;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
        write_data = '0;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] d;
        logic [31:0] exp;
        exp = (sb.size() != 0) ? sb.pop_front() : 32'h0;
        bus_rd(2'd0, d);
        check_eq(tag, d, exp);
    endtask

    task automatic reg_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(a, d);
        check_eq(tag, d, exp);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        drops_m = 0;
        rst = 1'b1;
        chipselect = 1'b0; address = '0; read = 1'b0; write = 1'b0; write_data = '0;
        source_valid = 1'b0; source_data = '0; source_channel = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_eq("rst_rdata", read_data, 32'h0);
        check_eq("rst_irq", 32'(irq), 32'h0);
        check_eq("rst_ready", 32'(source_ready), 32'h3);
        reg_check("rst_status", 2'd1, 32'h0001_0000);
        reg_check("rst_ctrl", 2'd2, 32'h0);

        // Basic tagged ordering
        push(1'b0, 28'h0000001);
        push(1'b1, 28'h0000002);
        push(1'b0, 28'h0000003);
        pop_check("basic0");
        pop_check("basic1");
        pop_check("basic2");
        reg_check("basic_status", 2'd1, 32'h0001_0000);

        // Fill to full, then overflow
        for (int i = 0; i < DEPTH; i++) push(1'(i), 28'(i * 3 + 11));
        check_eq("full_ready", 32'(source_ready), 32'h0);
        for (int i = 0; i < 5; i++) push(1'b1, 28'hABCDEF0);
        reg_check("drops5", 2'd3, 32'(drops_m));
        reg_check("full_status", 2'd1, 32'h0006_0800);
        pop_check("full_first");
        bus_wr(2'd3, 32'h1234);
        drops_m = 0;
        reg_check("drops_clr", 2'd3, 32'h0);
        reg_check("clr_status", 2'd1, 32'h0000_07FF);
        for (int i = 0; i < DEPTH - 1; i++) pop_check("drain_full");

        // Underflow
        pop_check("udf_data");
        reg_check("udf_status", 2'd1, 32'h0009_0000);
        bus_wr(2'd3, 32'h0);

        // Watermark interrupt
        bus_wr(2'd2, 32'h0001_0004);
        reg_check("ctrl_rb", 2'd2, 32'h0001_0004);
        for (int i = 0; i < 3; i++) push(1'b0, 28'(100 + i));
        @(negedge clk); @(negedge clk);
        check_eq("irq_below", 32'(irq), 32'h0);
        push(1'b1, 28'h0000103);
        check_eq("irq_lat", 32'(irq), 32'h0);
        @(negedge clk);
        check_eq("irq_set", 32'(irq), 32'h1);
        pop_check("irq_pop");
        @(negedge clk);
        check_eq("irq_clr", 32'(irq), 32'h0);
        for (int i = 0; i < 3; i++) pop_check("irq_drain");
        bus_wr(2'd2, 32'h0);

        // Continuous push+pop across pointer wrap
        for (int i = 0; i < 8; i++) push(1'(i), 28'(200 + i));
        for (int i = 0; i < 4096; i++) begin
            logic [31:0] exp;
            source_valid   = 1'b1;
            source_channel = 1'(i);
            source_data    = 28'(i * 7 + 5);
            chipselect     = 1'b1;
            read           = 1'b1;
            address        = 2'd0;
            exp = sb.pop_front();
            sb.push_back(32'({1'(i), 28'(i * 7 + 5)}));
            @(negedge clk);
            check_eq("stream", read_data, exp);
        end
        source_valid = 1'b0;
        chipselect   = 1'b0;
        read         = 1'b0;
        reg_check("stream_level", 2'd1, 32'h0000_0008);
        for (int i = 0; i < 8; i++) pop_check("stream_drain");

        // Flush with a concurrent push
        for (int i = 0; i < 100; i++) push(1'(i), 28'(300 + i));
        source_valid = 1'b1;
        source_data  = 28'h5555555;
        chipselect   = 1'b1;
        write        = 1'b1;
        address      = 2'd2;
        write_data   = 32'h0002_0000;
        @(negedge clk);
        source_valid = 1'b0;
        chipselect   = 1'b0;
        write        = 1'b0;
        write_data   = '0;
        sb.delete();
        reg_check("flush_status", 2'd1, 32'h0001_0000);
        reg_check("flush_ctrl", 2'd2, 32'h0);
        push(1'b1, 28'h0000777);
        pop_check("post_flush");

        // Async reset mid-stream
        bus_wr(2'd2, 32'h0001_0001);
        for (int i = 0; i < 10; i++) push(1'(i), 28'(400 + i));
        @(negedge clk);
        check_eq("pre_rst_irq", 32'(irq), 32'h1);
        pop_check("pre_rst_data");
        #2 rst = 1'b1;
        #1;
        check_eq("arst_rdata", read_data, 32'h0);
        check_eq("arst_irq", 32'(irq), 32'h0);
        check_eq("arst_ready", 32'(source_ready), 32'h3);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        drops_m = 0;
        @(negedge clk);
        reg_check("arst_status", 2'd1, 32'h0001_0000);
        reg_check("arst_ctrl", 2'd2, 32'h0);
        pop_check("arst_empty");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
